// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and byte type used by receiver, transmitter and the rx FIFO.
package uart_pkg;
    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port array, synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO behind uart_receiver with occupancy flags.
// Define UART_RX_FIFO_OVERRUN_EN to add the sticky overrun flag and its clear input.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_strobe,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
`ifdef UART_RX_FIFO_OVERRUN_EN
    output logic                     overrun,
    input  logic                     overrun_clr,
`endif
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW:0]       wp, rp;
    logic [DATA_W-1:0] mem_rdata;
    logic              push, pop;

    // Extra pointer MSB lets wp - rp reach DEPTH without ambiguity.
    assign count    = wp - rp;
    assign full     = count == CNT_FULL;
    assign empty    = wp == rp;
    assign rd_valid = !empty;
    assign pop      = rd_valid && rd_ready;
    assign push     = wr_strobe && (!full || pop);
    assign rd_data  = empty ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end

`ifdef UART_RX_FIFO_OVERRUN_EN
    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst)
        if (!rst)                           overrun <= 1'b0;
        else if (wr_strobe && !push)        overrun <= 1'b1;
        else if (overrun_clr)               overrun <= 1'b0;
`endif

    uart_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wp[AW-1:0]),
        .wdata (wr_data),
        .raddr (rp[AW-1:0]),
        .rdata (mem_rdata)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, corner sequences and random traffic against a queue model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_strobe = 1'b0;
    logic       rd_ready = 1'b0;
    logic       overrun_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty;
    logic [4:0] count;
`ifdef UART_RX_FIFO_OVERRUN_EN
    logic       overrun;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mq[$];
    bit         m_ovr = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .count     (count),
`ifdef UART_RX_FIFO_OVERRUN_EN
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
`endif
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        int         e_cnt;
        logic [7:0] e_data;
        logic       e_valid;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".count"}, int'(count), mq.size());
        chk({tag, ".empty"}, int'(empty), int'(mq.size() == 0));
        chk({tag, ".full"}, int'(full), int'(mq.size() == DEPTH));
        chk({tag, ".rd_valid"}, int'(rd_valid), int'(mq.size() != 0));
        chk({tag, ".rd_data"}, int'(rd_data), mq.size() != 0 ? int'(mq[0]) : 0);
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk({tag, ".overrun"}, int'(overrun), int'(m_ovr));
`endif
    endtask

    // One clock: drive, advance the queue model by the FIFO's rules, compare after the edge.
    task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r, input logic clr);
        int  n;
        bit  pop, push;
        wr_strobe = w; wr_data = d; rd_ready = r; overrun_clr = clr;
        n    = mq.size();
        pop  = n > 0 && r;
        push = w && (n < DEPTH || pop);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
`ifdef UART_RX_FIFO_OVERRUN_EN
        if (w && !push) m_ovr = 1;
        else if (clr)   m_ovr = 0;
`endif
        @(posedge clk); #1;
        wr_strobe = 0; rd_ready = 0; overrun_clr = 0;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mq.delete();
        m_ovr = 0;
    endtask

    function automatic logic [7:0] lsb_first(input logic [7:0] bits_in_order);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = bits_in_order[7-i];
        return b;
    endfunction

    initial begin
        logic [7:0] b0, b1;
        int         pushes;
        int         n;
        logic       w, r;
        // Serial bit order 1,0,1,0,1,1,0,0 and 0,1,1,1,0,0,1,1 written left-to-right.
        b0 = lsb_first(8'b1010_1100);
        b1 = lsb_first(8'b0111_0011);
        vt[0] = '{1, b0,    0, 1, 8'h35, 1};
        vt[1] = '{1, b1,    0, 2, 8'h35, 1};
        vt[2] = '{0, 8'h00, 1, 1, 8'hCE, 1};
        vt[3] = '{0, 8'h00, 1, 0, 8'h00, 0};
        vt[4] = '{0, 8'h00, 1, 0, 8'h00, 0};
        vt[5] = '{1, 8'h11, 1, 1, 8'h11, 1};
        vt[6] = '{1, 8'h22, 1, 1, 8'h22, 1};
        vt[7] = '{0, 8'h00, 0, 1, 8'h22, 1};
        vt[8] = '{0, 8'h00, 1, 0, 8'h00, 0};

        do_reset();
        check_model("reset");

        for (int i = 0; i < 9; i++) begin
            step("vec", vt[i].w, vt[i].d, vt[i].r, 0);
            chk($sformatf("vec%0d.count", i), int'(count), vt[i].e_cnt);
            chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vt[i].e_data));
            chk($sformatf("vec%0d.rd_valid", i), int'(rd_valid), int'(vt[i].e_valid));
        end

        // Fill past capacity: the 17th byte is dropped.
        do_reset();
        for (int i = 0; i < 17; i++) step("fill", 1, 8'(i), 0, 0);
        chk("fill.full", int'(full), 1);
        chk("fill.count", int'(count), 16);
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk("fill.overrun", int'(overrun), 1);
`endif
        for (int i = 0; i < 16; i++) begin
            chk("drain.data", int'(rd_data), i);
            step("drain", 0, 0, 1, 0);
        end
        chk("drain.empty", int'(empty), 1);
        step("ovr_clr", 0, 0, 0, 1);
`ifdef UART_RX_FIFO_OVERRUN_EN
        chk("ovr_clr.overrun", int'(overrun), 0);
        for (int i = 0; i < 16; i++) step("refill", 1, 8'h80, 0, 0);
        step("set_wins", 1, 8'h81, 0, 1);
        chk("set_wins.overrun", int'(overrun), 1);
        do_reset();
        check_model("reset2");
`endif

        // Full with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 16; i++) step("fill2", 1, 8'h40 + 8'(i), 0, 0);
        step("full_pp", 1, 8'hA5, 1, 0);
        chk("full_pp.count", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("full_pp.last", int'(rd_data), 8'hA5);
            step("drain2", 0, 0, 1, 0);
        end

        // Wrap-around with occupancy held between 3 and 5.
        pushes = 0;
        while (pushes < 40) begin
            n = mq.size();
            if (n < 3)       begin w = 1; r = 0; end
            else if (n == 3) begin w = 1; r = 1'($urandom_range(0, 1)); end
            else if (n == 4) begin w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
            else             begin w = 1'($urandom_range(0, 1)); r = 1; end
            if (w) pushes++;
            step("wrap", w, 8'($urandom), r, 0);
        end
        while (mq.size() != 0) step("wrap_drain", 0, 0, 1, 0);

        // Random traffic biased towards full and empty extremes.
        for (int i = 0; i < 400; i++) begin
            w = 1'($urandom_range(0, 99) < (i % 100 < 50 ? 80 : 25));
            r = 1'($urandom_range(0, 99) < (i % 100 < 50 ? 25 : 80));
            step("rand", w, 8'($urandom), r, 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between edges with data buffered.
        do_reset();
        for (int i = 0; i < 5; i++) step("pre_rst", 1, 8'h60 + 8'(i), 0, 0);
        #3 rst = 1'b0;
        #1;
        mq.delete();
        m_ovr = 0;
        chk("async_rst.count", int'(count), 0);
        chk("async_rst.rd_valid", int'(rd_valid), 0);
        check_model("async_rst");
        @(posedge clk); #1 rst = 1'b1;
        step("post_rst", 1, 8'h7E, 0, 0);
        chk("post_rst.data", int'(rd_data), 8'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of `uart_receiver`. It captures each byte presented on the receiver's `data_out` when `received_byte` pulses and holds it in a circular FIFO. The bytes are presented to the host/consumer logic through a first-word-fall-through valid/ready read port. It decouples the fixed-rate serial stream from a consumer that may stall, and reports occupancy and overrun.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, at least 2.
- `DATA_W`, 8, byte width; matches the receiver's `data_out`.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; one clock, reset asserted low clears all state immediately.
- `wr_data`  in  DATA_W  byte from the receiver's `data_out`.
- `wr_strobe`  in  1  one-cycle write request, driven from the receiver's `received_byte`.
- `rd_data`  out  DATA_W  head-of-queue byte; 0 when empty.
- `rd_valid`  out  1  head byte available (equals `!empty`).
- `rd_ready`  in  1  consumer accepts head byte this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `overrun`  out  1  sticky dropped-byte flag (present only with macro, see Configuration).
- `overrun_clr`  in  1  clears `overrun` (present only with macro).

## Operation
- Storage: DEPTH x DATA_W array, write pointer `wp` and read pointer `rp`, each $clog2(DEPTH)+1 bits. Index uses the low bits; the MSB distinguishes full from empty. Pointers wrap naturally modulo 2*DEPTH.
- Push: `wr_strobe && (!full || pop)`. Writes `wr_data` at `wp`, then `wp+1`.
- Pop: `rd_valid && rd_ready`. Then `rp+1`.
- `count` = `wp - rp` (registered or derived; must be cycle-exact with pointers).
- Simultaneous push and pop when full: the push is accepted. Count stays DEPTH and no byte is lost.
- Simultaneous `wr_strobe` and `rd_ready` when empty: no pop (`rd_valid` low). The push is accepted and count becomes 1.
- `wr_strobe` while full with no pop: the byte is dropped, pointers and count are unchanged, and an overrun event is recorded.
- `rd_ready` while empty is ignored.
- No state machine beyond the pointer pair. Behaviour is fully determined by the push/pop conditions above.

## Timing
- Reset values: `wp`=`rp`=0, `count`=0, `empty`=1, `full`=0, `rd_valid`=0, `rd_data`=0, `overrun`=0. Memory contents are not reset.
- Reset asserted mid-operation discards all buffered bytes asynchronously. The first push after deassertion lands at index 0.
- Write-to-read latency is 1 cycle. A byte pushed at edge N is on `rd_data` with `rd_valid` high after edge N.
- Pop takes effect at the edge where `rd_valid && rd_ready`. The next entry, or 0 with `rd_valid` low, appears after that edge.
- `rd_data` is combinational from array[`rp`], masked to 0 when empty. It is stable while `rd_valid && !rd_ready`.
- Sustains one push and one pop per cycle indefinitely.

## Configuration
- Macro `UART_RX_FIFO_OVERRUN_EN`.
- Defined: the `overrun` and `overrun_clr` ports exist. `overrun` sets on the edge after a dropped push and stays high until `overrun_clr` is sampled high.
  - If a drop and `overrun_clr` occur in the same cycle, set wins.
- Undefined: both ports are absent and drops are silent. All other behaviour is identical.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_W` = 8.
  - `UART_RX_FIFO_DEPTH` default = 16.
  - Typedef `uart_byte_t` (logic [7:0]).
  - Same package used by `uart_receiver` and the transmitter.
- One sub-module, `uart_fifo_mem`: simple dual-port array with one synchronous write port and one asynchronous read port, with no reset. Pointer and flag logic stays in `uart_rx_fifo`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles, then release → `empty`=1, `count`=0, `rd_valid`=0, `rd_data`=0x00, `overrun`=0.
- Receiver back-to-back: `uart_receiver` fed LSB-first 1,0,1,0,1,1,0,0 then 0,1,1,1,0,0,1,1 with `rd_ready`=0 → `count`=2. Then `rd_ready`=1 → `rd_data` 0x35 then 0xCE on consecutive cycles, then `empty`=1.
- Fill/overrun: 17 pushes 0x00..0x10 with `rd_ready`=0 at DEPTH=16 → `full`=1, `count`=16, `overrun`=1 after 17th. Drain returns 0x00..0x0F; 0x10 absent. `overrun_clr` pulse → `overrun`=0.
- Full with simultaneous push+pop: full FIFO, `wr_strobe` with 0xA5 and `rd_ready`=1 in the same cycle → `count` stays 16, `overrun` stays 0, 0xA5 read last.
- Wrap-around: 40 pushes interleaved with pops, occupancy held at 3–5 → output order exactly matches input order across pointer wraps. `count` always equals pushes minus pops.
- Mid-operation reset: 5 bytes buffered, assert `rst` low asynchronously between edges → `count`=0 and `rd_valid`=0 immediately. The next push of 0x7E reads back as 0x7E.
